// File: rtl/pc_control_unit.sv
// pc_control_unit
//   Registered program-counter unit. Holds the PC, produces pc+2 and the
//   PC-relative / register branch targets, evaluates the 3-bit condition
//   code against {N,Z,V}, and handles stall and halt.
//   Optional feature macro: PC_RAS_EN adds a RAS_DEPTH-entry circular
//   return-address stack driven by call/ret. Without it, call/ret are
//   ignored (plain branches) and ras_underflow is tied low.

module pc_control_unit #(
  parameter int                ADDR_W       = 16,
  parameter int                IMM_W        = 9,
  parameter int                RAS_DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt,
  input  logic              branch_en,
  input  logic              branch_reg,
  input  logic [2:0]        cond,
  input  logic [2:0]        flags,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2,
  output logic              flush,
  output logic              halted,
  output logic              ras_underflow
);

  localparam logic [0:0]        ST_RUN    = 1'b0;
  localparam logic [0:0]        ST_HALTED = 1'b1;
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(2);

  // Condition-code table; flags are {N,Z,V}.
  function automatic logic cond_true(input logic [2:0] c, input logic [2:0] f);
    logic n_v;
    logic z_v;
    logic v_v;
    logic r_v;
    n_v = f[2];
    z_v = f[1];
    v_v = f[0];
    case (c)
      3'b000:  r_v = ~z_v;
      3'b001:  r_v = z_v;
      3'b010:  r_v = ~z_v & ~n_v;
      3'b011:  r_v = n_v;
      3'b100:  r_v = z_v | (~z_v & ~n_v);
      3'b101:  r_v = n_v | z_v;
      3'b110:  r_v = v_v;
      3'b111:  r_v = 1'b1;
      default: r_v = 1'b0;
    endcase
    return r_v;
  endfunction

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              flush_q, flush_d;
  logic [0:0]        state_q, state_d;
  logic              halted_q, halted_d;

  logic [ADDR_W-1:0] pc_plus2_s;
  logic [ADDR_W-1:0] imm_sext_s;
  logic [ADDR_W-1:0] offset_s;
  logic [ADDR_W-1:0] rel_target_s;
  logic [ADDR_W-1:0] br_target_s;
  logic              taken_s;

  assign pc_plus2_s   = pc_q + PC_STEP;
  assign imm_sext_s   = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign offset_s     = {imm_sext_s[ADDR_W-2:0], 1'b0};
  assign rel_target_s = pc_plus2_s + offset_s;
  assign br_target_s  = branch_reg ? reg_target : rel_target_s;
  assign taken_s      = branch_en & cond_true(cond, flags);

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              uf_q, uf_d;
  logic [PTR_W-1:0]  ptr_inc_s;
  logic [PTR_W-1:0]  ptr_dec_s;

  assign ptr_inc_s = ptr_q + PTR_W'(1);
  assign ptr_dec_s = ptr_q - PTR_W'(1);
`else
  localparam int RAS_DEPTH_UNUSED = RAS_DEPTH;
  logic unused_ras_ports_s;
  assign unused_ras_ports_s = call ^ ret;
`endif

  // Next-state: stall > halt > branch in RUN; HALTED freezes everything.
  always_comb begin
    pc_d     = pc_q;
    flush_d  = 1'b0;
    state_d  = state_q;
`ifdef PC_RAS_EN
    ras_d    = ras_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    uf_d     = 1'b0;
`endif
    if (state_q == ST_RUN) begin
      if (stall) begin
        pc_d = pc_q;
      end else if (halt) begin
        state_d = ST_HALTED;
      end else if (taken_s) begin
`ifdef PC_RAS_EN
        if (ret && (cnt_q == CNT_W'(0))) begin
          // Return with nothing stacked: fall through and flag it.
          pc_d = pc_plus2_s;
          uf_d = 1'b1;
        end else if (ret && call) begin
          // Swap: jump to top, replace it with our own return address.
          pc_d         = ras_q[ptr_q];
          ras_d[ptr_q] = pc_plus2_s;
          flush_d      = 1'b1;
        end else if (ret) begin
          pc_d    = ras_q[ptr_q];
          ptr_d   = ptr_dec_s;
          cnt_d   = cnt_q - CNT_W'(1);
          flush_d = 1'b1;
        end else if (call) begin
          // Full stack: the slot past top is the oldest entry.
          pc_d             = br_target_s;
          ptr_d            = ptr_inc_s;
          ras_d[ptr_inc_s] = pc_plus2_s;
          if (cnt_q == CNT_FULL) begin
            cnt_d = cnt_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          flush_d = 1'b1;
        end else begin
          pc_d    = br_target_s;
          flush_d = 1'b1;
        end
`else
        pc_d    = br_target_s;
        flush_d = 1'b1;
`endif
      end else begin
        pc_d = pc_plus2_s;
      end
    end else begin
      pc_d = pc_q;
    end
    halted_d = (state_d == ST_HALTED);
  end

  // PC, flush and run/halt state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_VECTOR;
      flush_q  <= 1'b0;
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      flush_q  <= flush_d;
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

`ifdef PC_RAS_EN
  // Return-address stack storage, top pointer, occupancy and underflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= {ADDR_W{1'b0}};
      end
      ptr_q <= {PTR_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      uf_q  <= 1'b0;
    end else begin
      ras_q <= ras_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      uf_q  <= uf_d;
    end
  end

  assign ras_underflow = uf_q;
`else
  assign ras_underflow = 1'b0;
`endif

  assign pc       = pc_q;
  assign pc_plus2 = pc_plus2_s;
  assign flush    = flush_q;
  assign halted   = halted_q;

endmodule
